// File: rtl/kmeans_iter_ctrl.sv
// Iteration controller for a k-means clustering datapath: sequences accumulator clear,
// point assignment, centroid mean update and convergence check until converged or out of iterations.
module kmeans_iter_ctrl #(
  parameter int N_POINTS = 128,
  parameter int K        = 4,
  parameter int MAX_ITER = 32,
  localparam int PW      = $clog2(N_POINTS),
  localparam int KW      = (K > 1) ? $clog2(K) : 1,
  localparam int IW      = $clog2(MAX_ITER + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          converged,
  input  logic          pt_ready,
  output logic          valid,
  output logic [PW-1:0] point_idx,
  output logic          compute_mean,
  output logic [KW-1:0] cent_idx,
  output logic          clear_acc,
  output logic          busy,
  output logic          done,
  output logic          max_iter_hit,
  output logic [IW-1:0] iter_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_ASSIGN = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [PW-1:0] PT_LAST   = PW'(N_POINTS - 1);
  localparam logic [KW-1:0] CENT_LAST = KW'(K - 1);
  localparam logic [IW-1:0] ITER_LIM  = IW'(MAX_ITER);

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] pidx_q, pidx_d;
  logic [KW-1:0] cidx_q, cidx_d;
  logic [IW-1:0] iter_q, iter_d;
  logic          hit_q, hit_d;
  logic [IW-1:0] iter_inc_s;

  assign iter_inc_s = iter_q + IW'(1);

  // Next-state and counter update; abort overrides every non-idle transition.
  always_comb begin
    state_d = state_q;
    pidx_d  = pidx_q;
    cidx_d  = cidx_q;
    iter_d  = iter_q;
    hit_d   = hit_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          iter_d  = '0;
          hit_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        state_d = S_ASSIGN;
        pidx_d  = '0;
      end
      S_ASSIGN: begin
        if (pt_ready) begin
          if (pidx_q == PT_LAST) begin
            state_d = S_UPDATE;
            pidx_d  = '0;
            cidx_d  = '0;
          end else begin
            pidx_d  = pidx_q + PW'(1);
          end
        end else begin
          pidx_d = pidx_q;
        end
      end
      S_UPDATE: begin
        if (cidx_q == CENT_LAST) begin
          state_d = S_CHECK;
          cidx_d  = '0;
        end else begin
          cidx_d  = cidx_q + KW'(1);
        end
      end
      S_CHECK: begin
        iter_d = iter_inc_s;
        // Convergence wins over the limit, so a converged final pass is not flagged.
        if (converged || (iter_inc_s == ITER_LIM)) begin
          state_d = S_DONE;
          hit_d   = ~converged;
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        pidx_d  = '0;
        cidx_d  = '0;
      end
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      pidx_d  = '0;
      cidx_d  = '0;
    end else begin
      state_d = state_d;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pidx_q  <= '0;
      cidx_q  <= '0;
      iter_q  <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pidx_q  <= pidx_d;
      cidx_q  <= cidx_d;
      iter_q  <= iter_d;
      hit_q   <= hit_d;
    end
  end

  assign valid        = (state_q == S_ASSIGN);
  assign compute_mean = (state_q == S_UPDATE);
  assign clear_acc    = (state_q == S_CLEAR);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign point_idx    = pidx_q;
  assign cent_idx     = cidx_q;
  assign iter_count   = iter_q;
  assign max_iter_hit = hit_q;

endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// Directed bench for kmeans_iter_ctrl with N_POINTS=4, K=2, MAX_ITER=3; all outputs are
// packed into one vector per cycle and compared against hand-computed values.
module tb_kmeans_iter_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       converged;
  logic       pt_ready;
  logic       valid;
  logic [1:0] point_idx;
  logic       compute_mean;
  logic [0:0] cent_idx;
  logic       clear_acc;
  logic       busy;
  logic       done;
  logic       max_iter_hit;
  logic [1:0] iter_count;

  int total_cnt;
  int bad_cnt;

  kmeans_iter_ctrl #(.N_POINTS(4), .K(2), .MAX_ITER(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .converged    (converged),
    .pt_ready     (pt_ready),
    .valid        (valid),
    .point_idx    (point_idx),
    .compute_mean (compute_mean),
    .cent_idx     (cent_idx),
    .clear_acc    (clear_acc),
    .busy         (busy),
    .done         (done),
    .max_iter_hit (max_iter_hit),
    .iter_count   (iter_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {valid, compute_mean, clear_acc, busy, done, max_iter_hit, point_idx, cent_idx, iter_count}
  function automatic logic [10:0] mk(input int v, input int cm, input int ca, input int b,
                                     input int d, input int h, input int p, input int c, input int i);
    return {v[0], cm[0], ca[0], b[0], d[0], h[0], p[1:0], c[0], i[1:0]};
  endfunction

  function automatic logic [10:0] obs();
    return {valid, compute_mean, clear_acc, busy, done, max_iter_hit, point_idx, cent_idx, iter_count};
  endfunction

  task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called while in CLEAR; walks one full pass and leaves after the CHECK exit edge.
  task automatic do_pass(input int it);
    chk("clear", obs(), mk(0, 0, 1, 1, 0, 0, 0, 0, it));
    for (int p = 0; p < 4; p++) begin
      tick();
      chk("assign", obs(), mk(1, 0, 0, 1, 0, 0, p, 0, it));
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("update", obs(), mk(0, 1, 0, 1, 0, 0, 0, c, it));
    end
    tick();
    chk("check", obs(), mk(0, 0, 0, 1, 0, 0, 0, 0, it));
    tick();
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    converged = 1'b0;
    pt_ready  = 1'b1;
    tick();
    tick();
    chk("reset", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    tick();
    chk("idle_after_reset", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Single converged pass
    converged = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    do_pass(0);
    chk("done_conv", obs(), mk(0, 0, 0, 1, 1, 0, 0, 0, 1));
    tick();
    chk("idle_conv", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1));

    // Never converges: iteration limit ends the run
    converged = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    do_pass(0);
    do_pass(1);
    do_pass(2);
    chk("done_limit", obs(), mk(0, 0, 0, 1, 1, 1, 0, 0, 3));
    tick();
    chk("idle_limit", obs(), mk(0, 0, 0, 0, 0, 1, 0, 0, 3));
    tick();
    tick();
    chk("idle_hold", obs(), mk(0, 0, 0, 0, 0, 1, 0, 0, 3));

    // Stall while point_idx=2, then converge exactly on the third check
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_clear", obs(), mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
    for (int p = 0; p < 3; p++) begin
      tick();
      chk("stall_assign", obs(), mk(1, 0, 0, 1, 0, 0, p, 0, 0));
    end
    pt_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall_hold", obs(), mk(1, 0, 0, 1, 0, 0, 2, 0, 0));
    end
    pt_ready = 1'b1;
    tick();
    chk("stall_p3", obs(), mk(1, 0, 0, 1, 0, 0, 3, 0, 0));
    tick();
    chk("stall_upd0", obs(), mk(0, 1, 0, 1, 0, 0, 0, 0, 0));
    tick();
    chk("stall_upd1", obs(), mk(0, 1, 0, 1, 0, 0, 0, 1, 0));
    tick();
    chk("stall_check", obs(), mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    tick();
    do_pass(1);
    converged = 1'b1;
    do_pass(2);
    chk("done_conv3", obs(), mk(0, 0, 0, 1, 1, 0, 0, 0, 3));
    tick();
    chk("idle_conv3", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 3));

    // Abort in second-pass UPDATE at cent_idx=1
    converged = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    do_pass(0);
    chk("abort_clear", obs(), mk(0, 0, 1, 1, 0, 0, 0, 0, 1));
    for (int p = 0; p < 6; p++) tick();
    chk("abort_pre", obs(), mk(0, 1, 0, 1, 0, 0, 0, 1, 1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    tick();
    chk("abort_nodone", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    converged = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    do_pass(0);
    chk("post_abort_done", obs(), mk(0, 0, 0, 1, 1, 0, 0, 0, 1));
    tick();

    // Abort beats pt_ready on the last point
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < 4; p++) tick();
    chk("abort2_pre", obs(), mk(1, 0, 0, 1, 0, 0, 3, 0, 0));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort2_idle", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // start held during a run is ignored; rst mid-ASSIGN clears everything
    converged = 1'b0;
    start = 1'b1;
    tick();
    do_pass(0);
    chk("busy_start_clear", obs(), mk(0, 0, 1, 1, 0, 0, 0, 0, 1));
    for (int p = 0; p < 3; p++) begin
      tick();
      chk("busy_start_assign", obs(), mk(1, 0, 0, 1, 0, 0, p, 0, 1));
    end
    rst = 1'b1;
    tick();
    chk("rst_mid", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    start = 1'b0;
    tick();
    chk("rst_idle", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/kmeans_iter_ctrl.md
KMEANS_ITER_CTRL -- requirements
Module: kmeans_iter_ctrl

Interface
REQ-001 Parameter N_POINTS, default 128, points per pass; legal range >= 2.
REQ-002 Parameter K, default 4, clusters updated per pass; legal range >= 1.
REQ-003 Parameter MAX_ITER, default 32, iteration limit; legal range >= 1.
REQ-004 Derived widths SHALL be: PW = clog2(N_POINTS), KW = max(1, clog2(K)), IW = clog2(MAX_ITER+1).
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  reset; synchronous and active-high.
REQ-007 start  in  1  begin clustering run; sampled only in IDLE.
REQ-008 abort  in  1  terminate run; sampled in every non-IDLE state.
REQ-009 converged  in  1  datapath convergence flag; sampled only in CHECK.
REQ-010 pt_ready  in  1  datapath accepts the current point this cycle.
REQ-011 valid  out  1  point presented to distance/assign datapath.
REQ-012 point_idx  out  PW  index of the presented point.
REQ-013 compute_mean  out  1  centroid mean update strobe.
REQ-014 cent_idx  out  KW  centroid being updated.
REQ-015 clear_acc  out  1  clear cluster accumulators.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle run-complete pulse.
REQ-018 max_iter_hit  out  1  last run ended on the iteration limit.
REQ-019 iter_count  out  IW  completed iterations of the current/last run.

Function
REQ-020 FSM states SHALL be IDLE, CLEAR, ASSIGN, UPDATE, CHECK, DONE; valid, compute_mean, clear_acc, busy and done SHALL be decoded from the state register only (Moore).
REQ-021 IDLE: start=1 -> CLEAR, with iter_count <= 0 and max_iter_hit <= 0; start in any other state SHALL be ignored.
REQ-022 CLEAR: clear_acc=1 for exactly one cycle -> ASSIGN, with point_idx = 0.
REQ-023 ASSIGN: valid=1; point_idx SHALL advance by 1 only on cycles with pt_ready=1 and SHALL hold otherwise.
REQ-024 ASSIGN with point_idx = N_POINTS-1 and pt_ready=1 -> UPDATE, with point_idx wrapping to 0.
REQ-025 UPDATE: compute_mean=1; cent_idx SHALL step 0..K-1, one value per cycle; after cent_idx = K-1 -> CHECK, with cent_idx <= 0; for K=1, UPDATE SHALL last one cycle.
REQ-026 CHECK: one cycle; on exit, iter_count SHALL increment by 1.
REQ-027 CHECK exit when converged=1 or iter_count+1 = MAX_ITER -> DONE; otherwise -> CLEAR.
REQ-028 On a CHECK exit to DONE, max_iter_hit SHALL be set to 1 only when converged=0; converged=1 takes priority over the limit.
REQ-029 DONE: done=1 for one cycle -> IDLE.
REQ-030 iter_count and max_iter_hit SHALL hold their values in IDLE until the next accepted start or reset.
REQ-031 abort=1 in any non-IDLE state SHALL force IDLE on the next edge.
  - done never pulses on abort.
  - point_idx and cent_idx return to 0.
  - iter_count is held.
  - abort has priority over pt_ready, converged and the limit.
REQ-032 Outputs outside their active state SHALL be 0: valid, compute_mean, clear_acc, done.
  - point_idx and cent_idx read 0 outside ASSIGN and UPDATE respectively.
REQ-033 No counter SHALL exceed its terminal value: point_idx <= N_POINTS-1, cent_idx <= K-1, iter_count <= MAX_ITER.

Reset
REQ-034 rst=1 on a rising edge SHALL force IDLE and zero all outputs and counters, from any state including mid-run; rst has priority over abort and start.

Verification (N_POINTS=4, K=2, MAX_ITER=3)
REQ-035 start pulse at edge 0, pt_ready=1, converged=1 -> expected sequence:
  - CLEAR at cycle 1; ASSIGN at cycles 2-5 with point_idx 0,1,2,3.
  - UPDATE at cycles 6-7 with cent_idx 0,1; CHECK at cycle 8.
  - done=1 at cycle 9; then iter_count=1, max_iter_hit=0.
REQ-036 converged=0 throughout -> three CLEAR/ASSIGN/UPDATE/CHECK passes, then done pulse; iter_count=3, max_iter_hit=1.
REQ-037 pt_ready=0 for 3 cycles while point_idx=2 -> point_idx holds 2 and valid stays 1; ASSIGN lasts 7 cycles instead of 4.
REQ-038 abort=1 during UPDATE (cent_idx=1) -> next cycle IDLE, busy=0, no done; a new start then runs normally from iter_count=0.
REQ-039 rst=1 mid-ASSIGN (point_idx=2) -> next cycle all outputs 0; a start asserted during busy has no effect.
REQ-040 Third CHECK with converged=1 -> done pulses with iter_count=3 and max_iter_hit=0.
